// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU entry sequencer: the state encoding that is also
// exported on state_o for the LED/display mux.
package alu_seq_pkg;

    localparam int ST_W = 3;

    typedef enum logic [ST_W-1:0] {
        S_WAIT_A  = 3'd0,
        S_WAIT_B  = 3'd1,
        S_WAIT_OP = 3'd2,
        S_UPD     = 3'd3,
        S_SHOW    = 3'd4
    } state_t;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector for a debounced button level. The history register
// resets to RESET_VAL so a button held through reset gives no edge.
module edge_detect #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic level_i,
    output logic rise_o
);

    logic level_q;

    // NOTE: sequential state is written with non-blocking assignments only,
    // so every register samples the pre-edge value of its inputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            level_q <= RESET_VAL;
        end else begin
            level_q <= level_i;
        end
    end

    assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/alu_sequencer.sv
// Two-button controller that walks the user through operand A, operand B and
// opcode entry, then fires the result-update strobe and holds the display.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT = 100_000_000
) (
    input  logic            Clk,
    input  logic            reset,
    input  logic            enter,
    input  logic            undo,
    output logic            load_A,
    output logic            load_B,
    output logic            load_Op,
    output logic            updateRes,
    output logic [ST_W-1:0] state_o,
    output logic            result_valid
);

    localparam int CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    logic ent_e;
    logic und_e;

    edge_detect #(.RESET_VAL(1'b1)) u_enter_edge (
        .clk_i   (Clk),
        .reset_i (reset),
        .level_i (enter),
        .rise_o  (ent_e)
    );

    edge_detect #(.RESET_VAL(1'b1)) u_undo_edge (
        .clk_i   (Clk),
        .reset_i (reset),
        .level_i (undo),
        .rise_o  (und_e)
    );

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             load_a_q, load_a_d;
    logic             load_b_q, load_b_d;
    logic             load_op_q, load_op_d;
    logic             upd_q, upd_d;
    logic             valid_q;
    logic             cnt_active;
    logic             timeout_hit;

    assign cnt_active  = (state_q == S_WAIT_B) || (state_q == S_WAIT_OP);
    assign timeout_hit = (TIMEOUT != 0) && cnt_active && (cnt_q == CNT_LAST);

    // NOTE: every signal driven here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        state_d   = state_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_op_d = 1'b0;
        upd_d     = 1'b0;
        unique case (state_q)
            S_WAIT_A: begin
                if (ent_e && !und_e) begin
                    state_d  = S_WAIT_B;
                    load_a_d = 1'b1;
                end
            end
            S_WAIT_B: begin
                if (und_e) begin
                    state_d = S_WAIT_A;
                end else if (ent_e) begin
                    state_d  = S_WAIT_OP;
                    load_b_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_WAIT_A;
                end
            end
            S_WAIT_OP: begin
                if (und_e) begin
                    state_d = S_WAIT_B;
                end else if (ent_e) begin
                    state_d   = S_UPD;
                    load_op_d = 1'b1;
                end else if (timeout_hit) begin
                    state_d = S_WAIT_A;
                end
            end
            // Opcode register updates as we enter S_UPD, so the result strobe
            // one cycle later captures the ALU output for the new opcode.
            S_UPD: begin
                state_d = S_SHOW;
                upd_d   = 1'b1;
            end
            S_SHOW: begin
                if (und_e) begin
                    state_d = S_WAIT_OP;
                end else if (ent_e) begin
                    state_d = S_WAIT_A;
                end
            end
            default: begin
                state_d = S_WAIT_A;
            end
        endcase
    end

    // Any user activity or state move restarts the idle count.
    always_comb begin
        cnt_d = '0;
        if ((TIMEOUT != 0) && cnt_active && (state_d == state_q) && !ent_e && !und_e) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            state_q   <= S_WAIT_A;
            cnt_q     <= '0;
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            load_op_q <= 1'b0;
            upd_q     <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            load_op_q <= load_op_d;
            upd_q     <= upd_d;
            valid_q   <= (state_q == S_SHOW);
        end
    end

    assign load_A       = load_a_q;
    assign load_B       = load_b_q;
    assign load_Op      = load_op_q;
    assign updateRes    = upd_q;
    assign state_o      = state_q;
    assign result_valid = valid_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a constant vector table, directed
// corner-case sequences and random button activity against a reference model.
module tb_alu_sequencer;

    logic       Clk = 1'b0;
    logic       reset = 1'b1;
    logic       en0 = 1'b0, un0 = 1'b0;
    logic       en8 = 1'b0, un8 = 1'b0;
    logic       la0, lb0, lo0, up0, rv0;
    logic       la8, lb8, lo8, up8, rv8;
    logic [2:0] st0, st8;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    alu_sequencer #(.TIMEOUT(0)) dut0 (
        .Clk (Clk), .reset (reset), .enter (en0), .undo (un0),
        .load_A (la0), .load_B (lb0), .load_Op (lo0), .updateRes (up0),
        .state_o (st0), .result_valid (rv0)
    );

    alu_sequencer #(.TIMEOUT(8)) dut8 (
        .Clk (Clk), .reset (reset), .enter (en8), .undo (un8),
        .load_A (la8), .load_B (lb8), .load_Op (lo8), .updateRes (up8),
        .state_o (st8), .result_valid (rv8)
    );

    wire [3:0] stb0 = {up0, lo0, lb0, la0};
    wire [3:0] stb8 = {up8, lo8, lb8, la8};

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: position in the entry sequence plus an idle counter.
    // Index 0 = TIMEOUT 0 instance, index 1 = TIMEOUT 8 instance.
    int         tmo[2]    = '{0, 8};
    int         fwd[5]    = '{1, 2, 3, 4, 0};
    int         back[5]   = '{0, 0, 1, 2, 2};
    int         m_st[2]   = '{0, 0};
    int         m_idle[2] = '{0, 0};
    bit         m_pe[2]   = '{1, 1};
    bit         m_pu[2]   = '{1, 1};
    int         x_st[2]   = '{0, 0};
    logic [3:0] x_stb[2]  = '{4'b0, 4'b0};
    bit         x_rv[2]   = '{0, 0};

    task automatic model_step(input int k, input bit rst, input bit en, input bit un);
        bit e, u;
        int nxt;
        if (rst) begin
            m_st[k] = 0; m_idle[k] = 0; m_pe[k] = 1; m_pu[k] = 1;
            x_st[k] = 0; x_stb[k] = 4'b0; x_rv[k] = 0;
            return;
        end
        e = en && !m_pe[k];
        u = un && !m_pu[k];
        x_rv[k]  = (m_st[k] == 4);
        x_stb[k] = 4'b0;
        nxt = m_st[k];
        if (m_st[k] == 3) begin
            nxt = 4;
            x_stb[k] = 4'b1000;
        end else if (u) begin
            nxt = back[m_st[k]];
        end else if (e) begin
            nxt = fwd[m_st[k]];
            if (m_st[k] < 3) x_stb[k] = 4'(1 << m_st[k]);
        end else if ((m_st[k] == 1 || m_st[k] == 2) && tmo[k] > 0 && m_idle[k] == tmo[k] - 1) begin
            nxt = 0;
        end
        m_idle[k] = ((m_st[k] == 1 || m_st[k] == 2) && nxt == m_st[k] && !e && !u && tmo[k] > 0)
                    ? m_idle[k] + 1 : 0;
        m_st[k] = nxt;
        m_pe[k] = en;
        m_pu[k] = un;
        x_st[k] = nxt;
    endtask

    task automatic tick();
        @(posedge Clk);
        model_step(0, reset, en0, un0);
        model_step(1, reset, en8, un8);
        #1;
        check("mdl0_state", st0, x_st[0]);
        check("mdl0_strobes", stb0, x_stb[0]);
        check("mdl0_valid", rv0, x_rv[0]);
        check("mdl8_state", st8, x_st[1]);
        check("mdl8_strobes", stb8, x_stb[1]);
        check("mdl8_valid", rv8, x_rv[1]);
    endtask

    typedef struct {
        logic       rst;
        logic       en;
        logic       un;
        int         st;
        logic [3:0] stb;
        logic       rv;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic e, input logic u,
                       input int s, input logic [3:0] b, input logic v);
        vec_t t;
        t.rst = r; t.en = e; t.un = u; t.st = s; t.stb = b; t.rv = v;
        vecs.push_back(t);
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  n;
        bit  seen_b;

        // Strobes are {updateRes, load_Op, load_B, load_A}.
        add(1, 0, 0, 0, 4'b0000, 0);
        add(0, 0, 0, 0, 4'b0000, 0);
        add(0, 1, 0, 1, 4'b0001, 0);
        add(0, 1, 0, 1, 4'b0000, 0);
        add(0, 0, 0, 1, 4'b0000, 0);
        add(0, 1, 0, 2, 4'b0010, 0);
        add(0, 0, 0, 2, 4'b0000, 0);
        add(0, 1, 0, 3, 4'b0100, 0);
        add(0, 0, 0, 4, 4'b1000, 0);
        add(0, 0, 0, 4, 4'b0000, 1);
        add(0, 1, 0, 0, 4'b0000, 1);
        add(0, 0, 0, 0, 4'b0000, 0);
        add(0, 0, 1, 0, 4'b0000, 0);
        add(0, 0, 0, 0, 4'b0000, 0);
        add(0, 1, 0, 1, 4'b0001, 0);
        add(0, 0, 0, 1, 4'b0000, 0);
        add(0, 1, 0, 2, 4'b0010, 0);
        add(0, 0, 0, 2, 4'b0000, 0);
        add(0, 1, 1, 1, 4'b0000, 0);
        add(0, 0, 0, 1, 4'b0000, 0);
        add(0, 1, 0, 2, 4'b0010, 0);
        add(0, 0, 0, 2, 4'b0000, 0);
        add(0, 1, 0, 3, 4'b0100, 0);
        add(0, 0, 0, 4, 4'b1000, 0);
        add(0, 0, 1, 2, 4'b0000, 1);
        add(0, 0, 0, 2, 4'b0000, 0);
        add(0, 1, 0, 3, 4'b0100, 0);
        add(0, 0, 0, 4, 4'b1000, 0);
        add(0, 0, 0, 4, 4'b0000, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            reset = vecs[i].rst;
            en0   = vecs[i].en;
            un0   = vecs[i].un;
            tick();
            check($sformatf("vec%0d_state", i), st0, vecs[i].st);
            check($sformatf("vec%0d_strobes", i), stb0, vecs[i].stb);
            check($sformatf("vec%0d_valid", i), rv0, vecs[i].rv);
        end

        // Enter held across reset release: no edge until a fresh press.
        reset = 1; en0 = 1; un0 = 0;
        tick();
        reset = 0;
        tick();
        check("held_no_load_A", la0, 0);
        check("held_state", st0, 0);
        tick();
        check("held_still_idle", st0, 0);
        en0 = 0;
        tick();
        en0 = 1;
        tick();
        check("repress_load_A", la0, 1);
        check("repress_state", st0, 1);
        en0 = 0;
        tick();

        // Reset in the S_UPD cycle swallows updateRes.
        en0 = 1; tick(); en0 = 0; tick();
        en0 = 1; tick();
        check("pre_upd_load_Op", lo0, 1);
        check("pre_upd_state", st0, 3);
        reset = 1; en0 = 0;
        tick();
        check("upd_reset_strobe", up0, 0);
        check("upd_reset_state", st0, 0);
        check("upd_reset_valid", rv0, 0);
        reset = 0;
        tick();
        check("upd_after_strobe", up0, 0);
        check("upd_after_valid", rv0, 0);

        // Timeout after 8 idle cycles in S_WAIT_B.
        en8 = 1;
        tick();
        check("tmo_load_A", la8, 1);
        en8 = 0;
        seen_b = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            seen_b |= lb8;
            n = i;
            if (st8 == 0) break;
        end
        check("tmo_wait_b_cycles", n, 8);
        check("tmo_no_load_B", seen_b, 0);

        // Undo at idle cycle 5 of S_WAIT_OP restarts the count in S_WAIT_B.
        en8 = 1; tick(); en8 = 0; tick();
        en8 = 1; tick(); en8 = 0;
        check("tmo_reach_op", st8, 2);
        for (int i = 0; i < 5; i++) tick();
        check("tmo_op_still", st8, 2);
        un8 = 1;
        tick();
        check("tmo_undo_state", st8, 1);
        un8 = 0;
        n = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            n = i;
            if (st8 == 0) break;
        end
        check("tmo_restart_cycles", n, 8);

        // Random button activity on both instances.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 2) == 0) en0 = ~en0;
            if ($urandom_range(0, 4) == 0) un0 = ~un0;
            if ($urandom_range(0, 7) == 0) en8 = ~en8;
            if ($urandom_range(0, 11) == 0) un8 = ~un8;
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
FSM controller that drives the register ALU's load strobes from one "enter" button and one "undo" button. The user enters operand A, then operand B, then the opcode, all on the shared data_in switches. The block then issues the result-update strobe and holds the result display.
Sits between the debounced push-button inputs and the register ALU top level. It replaces direct wiring of the load_A, load_B, load_Op and updateRes buttons.

Parameters:
TIMEOUT, 100_000_000, idle cycles allowed in S_WAIT_B or S_WAIT_OP before abort to S_WAIT_A; 0 disables the timeout.
CNT_W, $clog2(TIMEOUT+1) (minimum 1), width of the timeout counter; derived, not overridden.

Ports:
Clk  input  1  system clock; all logic on its rising edge.
reset  input  1  synchronous, active-high reset.
enter  input  1  debounced level from the enter button; its rising edge advances the FSM.
undo  input  1  debounced level from the undo button; its rising edge steps back one state.
load_A  output  1  one-cycle strobe to the ALU operand-A register.
load_B  output  1  one-cycle strobe to the ALU operand-B register.
load_Op  output  1  one-cycle strobe to the ALU opcode register.
updateRes  output  1  one-cycle strobe to the ALU result/flags register.
state_o  output  3  encoded current state, for LEDs/display mux.
result_valid  output  1  high while the FSM is in S_SHOW.

Behaviour:
- Edge detection
  - enter_q and undo_q are registered copies of the inputs; both reset to 1, so a button held through reset produces no edge.
  - ent_e = enter & ~enter_q; und_e = undo & ~undo_q.
- States (state_o encoding): S_WAIT_A=0, S_WAIT_B=1, S_WAIT_OP=2, S_UPD=3, S_SHOW=4. Values 5..7 are illegal and return to S_WAIT_A on the next edge.
- Transitions when ent_e=1 and und_e=0:
  - S_WAIT_A -> S_WAIT_B, with load_A=1.
  - S_WAIT_B -> S_WAIT_OP, with load_B=1.
  - S_WAIT_OP -> S_UPD, with load_Op=1.
  - S_SHOW -> S_WAIT_A.
- S_UPD is transient: always -> S_SHOW on the next edge with updateRes=1. All inputs are ignored while in S_UPD.
- Transitions when und_e=1 (undo wins over a simultaneous ent_e; no strobes are issued):
  - S_WAIT_B -> S_WAIT_A.
  - S_WAIT_OP -> S_WAIT_B.
  - S_SHOW -> S_WAIT_OP.
  - S_WAIT_A: stays.
- Strobe timing
  - All strobes are registered and asserted for exactly one cycle.
  - A strobe is high in the cycle following the rising edge at which ent_e was sampled.
  - updateRes is high exactly one cycle after load_Op. The ALU therefore latches a result computed with the new opcode.
  - At most one strobe is high in any cycle.
- result_valid is a registered decode of state == S_SHOW.
- Timeout
  - The counter is active only in S_WAIT_B and S_WAIT_OP.
  - It clears on any state change, ent_e or und_e; otherwise it increments.
  - When it reaches TIMEOUT-1 the next state is S_WAIT_A, with no strobes.
  - In all other states the counter holds at 0. With TIMEOUT=0 the counter is forced to 0 and never fires.
- Reset
  - Outputs after reset: all strobes 0, result_valid 0, state S_WAIT_A, counter 0.
  - A reset asserted in S_UPD suppresses updateRes.
  - Reset has priority over every other event.
- Held buttons produce one edge only; there is no auto-repeat.

Decomposition:
- Package alu_seq_pkg holds:
  - typedef enum logic [2:0] state_t with the five states.
  - localparam ST_W=3.
- One sub-module, edge_detect, is natural. It is a rising-edge detector with a RESET_VAL parameter (set to 1 here) and is instanced twice, for enter and undo.
- FSM and timeout counter stay in alu_sequencer.

Test Plan:
1. Reset, then enter edges at cycles 10, 20 and 30 with TIMEOUT=0 -> load_A high in cycle 11, load_B in 21, load_Op in 31, updateRes in 32. state_o reads 1, 2, 3, 4; result_valid=1 from cycle 33. A 4th edge returns state_o=0.
2. Enter held high across reset deassertion -> no load_A. Release, then a new press -> load_A one cycle after the press.
3. In S_WAIT_OP, enter and undo rise in the same cycle -> state_o=1, all strobes stay 0.
4. TIMEOUT=8: load_A, then idle -> state_o returns to 0 after 8 cycles in S_WAIT_B with no load_B. An undo edge at idle cycle 5 instead restarts the count.
5. Reset asserted in the S_UPD cycle -> updateRes never asserts, state_o=0, result_valid=0.
6. In S_SHOW, undo then enter -> state_o goes 4, 2, 3, 4. The second load_Op is followed one cycle later by updateRes.
